entropy_poll_slave: RTL

Memory-mapped entropy source that services the load-word a pollentropy instruction is translated into, at the fixed physical address POLLENTROPY_PADDR. Sits on the CPU data-memory bus behind the address decoder and supplies the mem_rdata that the core writes to rd. It collects raw noise bits into 16-bit seeds, health-tests the noise stream, buffers seeds in a small FIFO, and returns OPST status plus seed per read.

---
 rtl/entropy_pkg.sv | 23 ++
 rtl/entropy_seed_fifo.sv | 56 +++++
 rtl/entropy_poll_slave.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/entropy_pkg.sv
// rtl/entropy_pkg.sv - shared types and response packing for the entropy poll slave
package entropy_pkg;

  localparam int ES_SEED_W = 16;

  typedef enum logic [1:0] {
    OPST_BIST = 2'b00,
    OPST_WAIT = 2'b01,
    OPST_ES16 = 2'b10,
    OPST_DEAD = 2'b11
  } opst_t;

  typedef enum logic [1:0] {
    ES_BIST,
    ES_RUN,
    ES_DEAD
  } es_state_t;

  function automatic logic [31:0] pack_resp(opst_t opst, logic [ES_SEED_W-1:0] seed);
    return {opst, 14'b0, seed};
  endfunction

endpackage

// File: rtl/entropy_seed_fifo.sv
// rtl/entropy_seed_fifo.sv - seed FIFO with wrap-bit pointers and flush
module entropy_seed_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full FIFO is pushing into.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/entropy_poll_slave.sv
// rtl/entropy_poll_slave.sv - memory-mapped pollentropy source: noise collection,
// repetition-count health test, seed buffering and single-outstanding bus responder
module entropy_poll_slave
  import entropy_pkg::*;
#(
  parameter logic [31:0] POLLENTROPY_PADDR = 32'h7000_0000,
  parameter int          FIFO_DEPTH        = 4,
  parameter int          BIST_CYCLES       = 64,
  parameter int          RCT_CUTOFF        = 32
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        noise_valid,
  input  logic        noise_bit,
  input  logic        mem_req,
  output logic        mem_gnt,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata,
  output logic        es_dead
);

  localparam int BW = $clog2(BIST_CYCLES + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  es_state_t            state_q, state_d;
  logic [BW-1:0]        bist_cnt_q, bist_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [ES_SEED_W-2:0] sreg_q, sreg_d;
  logic [RW-1:0]        run_q, run_d;
  logic                 last_q, last_d;
  logic                 pending_q, pending_d;
  logic                 err_q, err_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 dead_q;
  logic                 rct_fail;
  logic                 fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [ES_SEED_W-1:0] fifo_head;
  logic                 unused_bus;

  assign unused_bus = ^{mem_strb, mem_wdata};

  assign mem_gnt   = mem_req && !pending_q;
  assign mem_recv  = pending_q;
  assign mem_error = err_q;
  assign mem_rdata = rdata_q;
  assign es_dead   = dead_q;

  always_comb begin
    state_d    = state_q;
    bist_cnt_d = bist_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sreg_d     = sreg_q;
    run_d      = run_q;
    last_d     = last_q;
    pending_d  = pending_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    fifo_pop   = 1'b0;
    fifo_push  = 1'b0;
    rct_fail   = 1'b0;

    // Response is built from pre-edge state so a same-cycle push or RCT failure is not seen.
    if (pending_q && mem_ack) begin
      pending_d = 1'b0;
      err_d     = 1'b0;
      rdata_d   = '0;
    end else if (mem_gnt) begin
      pending_d = 1'b1;
      if (mem_wen || (mem_addr != POLLENTROPY_PADDR)) begin
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
        err_d = 1'b0;
        case (state_q)
          ES_DEAD: rdata_d = pack_resp(OPST_DEAD, '0);
          ES_RUN: begin
            if (fifo_empty) begin
              rdata_d = pack_resp(OPST_WAIT, '0);
            end else begin
              rdata_d  = pack_resp(OPST_ES16, fifo_head);
              fifo_pop = 1'b1;
            end
          end
          default: rdata_d = pack_resp(OPST_BIST, '0);
        endcase
      end
    end

    if (noise_valid && (state_q != ES_DEAD)) begin
      sreg_d    = {sreg_q[ES_SEED_W-3:0], noise_bit};
      bit_cnt_d = bit_cnt_q + 4'd1;
      fifo_push = (bit_cnt_q == 4'hF) && (state_q == ES_RUN) && (!fifo_full || fifo_pop);
      if (noise_bit != last_q) begin
        run_d = RW'(1);
      end else if (run_q != RW'(RCT_CUTOFF)) begin
        run_d = run_q + RW'(1);
      end
      last_d   = noise_bit;
      rct_fail = (run_d == RW'(RCT_CUTOFF));
    end

    case (state_q)
      ES_BIST: begin
        if (rct_fail) begin
          state_d = ES_DEAD;
        end else if (bist_cnt_q == BW'(BIST_CYCLES - 1)) begin
          state_d = ES_RUN;
        end else begin
          bist_cnt_d = bist_cnt_q + BW'(1);
        end
      end
      ES_RUN: if (rct_fail) state_d = ES_DEAD;
      default: ;
    endcase
  end

  assign fifo_flush = (state_d == ES_DEAD);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q    <= ES_BIST;
      bist_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sreg_q     <= '0;
      run_q      <= '0;
      last_q     <= 1'b0;
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      dead_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bist_cnt_q <= bist_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sreg_q     <= sreg_d;
      run_q      <= run_d;
      last_q     <= last_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      dead_q     <= (state_d == ES_DEAD);
    end
  end

  entropy_seed_fifo #(
    .WIDTH (ES_SEED_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (g_clk),
    .resetn_i (g_resetn),
    .push_i   (fifo_push),
    .data_i   ({sreg_q, noise_bit}),
    .pop_i    (fifo_pop),
    .flush_i  (fifo_flush),
    .data_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

endmodule
